fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control path. It owns the program counter and issues in-order requests to instruction memory over a req/gnt/rvalid interface. Returned words are buffered in a small FIFO and presented to decode as `Instr`/`PC` with a valid/ready handshake. The fetch stream redirects on the `PCSrc` decision that the control path returns for the instruction being consumed.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// Instruction fetch stage: owns the PC, issues in-order imem requests, buffers
// returned words and redirects on the control path's PCSrc for the popped instruction.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        InstrValid,
    input  logic        InstrReady
);

    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [CW:0]   CAP  = (CW+1)'(DEPTH);

    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, outstanding, discard;
    logic [CW-1:0] count_n, out_n, disc_n;
    logic [31:0]   fetch_pc, resp_pc;
    logic [31:0]   sel_target, target;
    logic          req_q, req_n;
    logic          grant, rsp, push, pop, redirect, valid;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST) ? '0 : p + AW'(1);
    endfunction

    assign valid      = (count != '0);
    assign grant      = req_q & imem_gnt;
    // A response with nothing outstanding is a protocol violation and is ignored.
    assign rsp        = imem_rvalid & (outstanding != '0);
    assign pop        = valid & InstrReady;
    assign redirect   = pop & ((PCSrc == 2'b01) | (PCSrc == 2'b10));
    assign push       = rsp & (discard == '0) & ~redirect;
    assign sel_target = (PCSrc == 2'b10) ? ALUResult : PCTarget;
    assign target     = sel_target & 32'hFFFF_FFFC;

    always_comb begin
        out_n   = outstanding + CW'(grant) - CW'(rsp);
        count_n = count + CW'(push) - CW'(pop);
        disc_n  = discard;
        if (redirect) begin
            // Everything still in flight, including a grant taken this cycle, is stale.
            count_n = '0;
            disc_n  = out_n;
        end else if (rsp && (discard != '0)) begin
            disc_n = discard - CW'(1);
        end
        req_n = ({1'b0, out_n} + {1'b0, count_n}) < CAP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            req_q       <= 1'b0;
        end else begin
            count       <= count_n;
            outstanding <= out_n;
            discard     <= disc_n;
            req_q       <= req_n;
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                fetch_pc <= target;
                resp_pc  <= target;
            end else begin
                if (pop)   rd_ptr   <= ptr_inc(rd_ptr);
                if (push)  wr_ptr   <= ptr_inc(wr_ptr);
                if (grant) fetch_pc <= fetch_pc + 32'd4;
                if (push)  resp_pc  <= resp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= resp_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = fetch_pc;
    assign InstrValid = valid;
    assign Instr      = valid ? fifo_instr[rd_ptr] : 32'h0000_0013;
    assign PC         = valid ? fifo_pc[rd_ptr] : 32'h0;
    assign PCPlus4    = PC + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// Randomized bench for fetch_unit: queue-based reference model plus an in-order
// memory responder, with literal checks pinning the directed scenarios.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] PCTarget = 32'h0;
    logic [31:0] ALUResult = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instr, PC, PCPlus4;
    logic        InstrValid;
    logic        InstrReady = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .PCTarget(PCTarget), .ALUResult(ALUResult),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC),
        .PCPlus4(PCPlus4), .InstrValid(InstrValid), .InstrReady(InstrReady)
    );

    typedef struct { logic [31:0] addr; bit stale; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

    req_t        infl[$];   // requests granted, response not yet seen
    ent_t        buff[$];   // words decode can see, head first
    logic [31:0] m_fpc;
    bit          started;
    int          edges, last_due;
    int          vectors = 0, miscompares = 0;

    int gnt_pct = 100, ready_pct = 100, redir_pct = 0, kmin = 1, kmax = 1, stall_pct = 0;
    bit data_is_addr = 1;

    function automatic bit m_req();
        return started && ((infl.size() + buff.size()) < DEPTH);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        infl.delete();
        buff.delete();
        m_fpc    = RESET_PC;
        started  = 0;
        last_due = 0;
    endtask

    // Advance the reference model (and the memory's request queue) by one edge.
    task automatic model_edge();
        bit grant, pop, redir;
        logic [31:0] tgt, addr;
        req_t e, r;
        ent_t n;
        int d;
        if (!rst_n) return;
        addr  = m_fpc;
        grant = m_req() && imem_gnt;
        pop   = (buff.size() > 0) && InstrReady;
        redir = pop && (PCSrc == 2'b01 || PCSrc == 2'b10);
        tgt   = (PCSrc == 2'b10) ? ALUResult : PCTarget;
        tgt[1:0] = 2'b00;
        if (pop) void'(buff.pop_front());
        if (imem_rvalid && infl.size() > 0) begin
            e = infl.pop_front();
            if (!e.stale && !redir) begin
                n.pc = e.addr;
                n.instr = imem_rdata;
                buff.push_back(n);
            end
        end
        if (redir) begin
            foreach (infl[i]) infl[i].stale = 1;
            buff.delete();
            m_fpc = tgt;
        end
        if (grant) begin
            d = edges + $urandom_range(kmin, kmax);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            r.addr = addr;
            r.stale = redir;
            r.due = d;
            infl.push_back(r);
            if (!redir) m_fpc = m_fpc + 32'd4;
        end
        started = 1;
    endtask

    task automatic drive();
        imem_gnt   = ($urandom_range(0, 99) < gnt_pct);
        InstrReady = ($urandom_range(0, 99) < ready_pct);
        if ($urandom_range(0, 99) < redir_pct) PCSrc = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
        else PCSrc = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
        PCTarget  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
        ALUResult = $urandom;
        if (infl.size() > 0 && infl[0].due <= edges + 1 && $urandom_range(0, 99) >= stall_pct) begin
            imem_rvalid = 1'b1;
            imem_rdata  = data_is_addr ? infl[0].addr : $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        edges++;
        model_edge();
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 40 && buff.size() == 0; i++) step();
        chk(name, 32'(InstrValid), 32'd1);
    endtask

    always @(negedge clk) begin : compare
        logic [31:0] hpc, hin;
        bit v;
        v   = buff.size() > 0;
        hpc = v ? buff[0].pc : 32'h0;
        hin = v ? buff[0].instr : 32'h0000_0013;
        chk("imem_req", 32'(imem_req), 32'(m_req()));
        chk("imem_addr", imem_addr, m_fpc);
        chk("InstrValid", 32'(InstrValid), 32'(v));
        chk("Instr", Instr, hin);
        chk("PC", PC, hpc);
        chk("PCPlus4", PCPlus4, hpc + 32'd4);
    end

    initial begin
        model_reset();
        edges = 0;

        // Streaming from reset, 1-cycle memory returning the address as data.
        do_reset();
        step();
        chk("a_req_first", 32'(imem_req), 32'd1);
        chk("a_addr_first", imem_addr, 32'h0);
        step();
        chk("a_addr_next", imem_addr, 32'h4);
        chk("a_not_yet_valid", 32'(InstrValid), 32'd0);
        step();
        chk("a_pc0", PC, 32'h0);
        chk("a_valid0", 32'(InstrValid), 32'd1);
        step();
        chk("a_pc4", PC, 32'h4);
        chk("a_instr4", Instr, 32'h4);
        step();
        chk("a_pc8", PC, 32'h8);
        repeat (10) step();

        // Decode stalled: buffer fills to DEPTH and requests stop.
        ready_pct = 0;
        do_reset();
        repeat (12) step();
        chk("b_req_full", 32'(imem_req), 32'd0);
        chk("b_head", PC, 32'h0);
        chk("b_addr", imem_addr, 32'h10);
        ready_pct = 100;
        InstrReady = 1'b1;
        step(); chk("b_pop4", PC, 32'h4);
        step(); chk("b_pop8", PC, 32'h8);
        step(); chk("b_pop12", PC, 32'hC);
        step(); chk("b_pop16", PC, 32'h10);

        // Branch redirect with a 3-cycle memory and stale responses in flight.
        kmin = 3; kmax = 3;
        do_reset();
        for (int i = 0; i < 40 && !(buff.size() > 0 && buff[0].pc == 32'h8); i++) step();
        chk("c_head8", PC, 32'h8);
        PCSrc = 2'b01; PCTarget = 32'h100; InstrReady = 1'b1;
        step();
        chk("c_redir_addr", imem_addr, 32'h100);
        chk("c_redir_flush", 32'(InstrValid), 32'd0);
        wait_valid("c_wait0");
        chk("c_tgt_pc0", PC, 32'h100);
        step();
        wait_valid("c_wait1");
        chk("c_tgt_pc1", PC, 32'h104);

        // jalr redirect with an unaligned target.
        wait_valid("d_wait");
        PCSrc = 2'b10; ALUResult = 32'h203; InstrReady = 1'b1;
        step();
        chk("d_jalr_addr", imem_addr, 32'h200);
        chk("d_jalr_flush", 32'(InstrValid), 32'd0);
        wait_valid("d_wait1");
        chk("d_jalr_pc", PC, 32'h200);
        repeat (10) step();

        // Grant withheld: request held, address stable, nothing pushed.
        kmin = 1; kmax = 1; gnt_pct = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("e_req_held", 32'(imem_req), 32'd1);
            chk("e_addr_held", imem_addr, RESET_PC);
            chk("e_no_push", 32'(InstrValid), 32'd0);
        end
        gnt_pct = 100;
        repeat (6) step();

        // Asynchronous reset with three entries buffered.
        ready_pct = 0;
        do_reset();
        for (int i = 0; i < 20 && buff.size() != 3; i++) step();
        chk("f_fill3", 32'(InstrValid), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("f_rst_valid", 32'(InstrValid), 32'd0);
        chk("f_rst_instr", Instr, 32'h13);
        chk("f_rst_pc", PC, 32'h0);
        chk("f_rst_pcp4", PCPlus4, 32'h4);
        chk("f_rst_req", 32'(imem_req), 32'd0);
        chk("f_rst_addr", imem_addr, RESET_PC);
        repeat (2) step();
        rst_n = 1'b1;
        ready_pct = 100;
        step();
        chk("f_restart_req", 32'(imem_req), 32'd1);
        chk("f_restart_addr", imem_addr, RESET_PC);
        repeat (8) step();

        // Randomized traffic, knobs re-drawn per segment, one reset midway.
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            gnt_pct      = $urandom_range(30, 100);
            ready_pct    = $urandom_range(20, 100);
            redir_pct    = $urandom_range(0, 30);
            kmin         = $urandom_range(1, 2);
            kmax         = $urandom_range(kmin, 5);
            stall_pct    = $urandom_range(0, 40);
            data_is_addr = ($urandom_range(0, 1) == 1);
            if (seg == 6) do_reset();
            repeat (250) step();
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
